// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences one single-port unified memory between the
// instruction-fetch port and the load/store data port. One access is in
// flight at a time: IDLE -> ISSUE -> WAIT (MEM_LAT-1 cycles) -> RESP.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin arbitration on
// contention; when undefined, data requests win over fetch requests.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic ID_FETCH = 1'b0;
    localparam logic ID_DATA  = 1'b1;

    // WAIT lasts MEM_LAT-1 cycles; the counter is only used when MEM_LAT > 1.
    localparam logic [3:0] WAIT_LOAD = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

    logic [1:0]        state, next_state;
    logic              lat_id;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_be;
    logic [3:0]        wait_cnt;

    logic in_issue, in_resp;
    logic any_req, accept, pick_data;

    assign in_issue = (state == S_ISSUE);
    assign in_resp  = (state == S_RESP);
    assign any_req  = if_req | d_req;
    // New requests are only taken in IDLE and in RESP (back-to-back).
    assign accept   = any_req & ((state == S_IDLE) | in_resp);

`ifdef MEM_ARB_RR_EN
    logic last_id;

    // On contention the requester not granted last wins.
    assign pick_data = d_req & (~if_req | (last_id == ID_FETCH));

    // Remember who was granted most recently; starts at fetch so data wins first.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            last_id <= ID_FETCH;
        else if (in_issue)
            last_id <= lat_id;
    end
`else
    // Fixed priority: data beats fetch.
    assign pick_data = d_req;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned
        // (which would infer a latch).
        next_state = state;
        case (state)
            S_IDLE:  if (any_req) next_state = S_ISSUE;
            S_ISSUE: next_state = (MEM_LAT > 1) ? S_WAIT : S_RESP;
            S_WAIT:  if (wait_cnt == 4'd0) next_state = S_RESP;
            S_RESP:  next_state = any_req ? S_ISSUE : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Capture the winning request; fetches carry no write, no wdata, no byte enables.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_id    <= ID_FETCH;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else if (accept) begin
            lat_id    <= pick_data ? ID_DATA : ID_FETCH;
            lat_we    <= pick_data & d_we;
            lat_addr  <= pick_data ? d_addr : if_addr;
            lat_wdata <= pick_data ? d_wdata : '0;
            lat_be    <= pick_data ? d_be : '0;
        end
    end

    // Memory latency countdown, loaded as the access is issued.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            wait_cnt <= 4'd0;
        else if (in_issue)
            wait_cnt <= WAIT_LOAD;
        else if ((state == S_WAIT) && (wait_cnt != 4'd0))
            wait_cnt <= wait_cnt - 4'd1;
    end

    // Outputs decode from registered state; everything idles at zero.
    always_comb begin
        mem_en    = in_issue;
        mem_we    = in_issue & lat_we;
        mem_addr  = in_issue ? lat_addr  : '0;
        mem_wdata = in_issue ? lat_wdata : '0;
        mem_be    = in_issue ? lat_be    : '0;
        if_gnt    = in_issue & (lat_id == ID_FETCH);
        d_gnt     = in_issue & (lat_id == ID_DATA);
        if_rvalid = in_resp  & (lat_id == ID_FETCH);
        d_rvalid  = in_resp  & (lat_id == ID_DATA);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = (d_rvalid & ~lat_we) ? mem_rdata : '0;
        busy      = (state != S_IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven single accesses plus hand-written contention,
// back-to-back, MEM_LAT=1 and reset-mid-access sequences. A small memory model
// answers reads; a scoreboard checks every issue and every response.
module tb_mem_arbiter;

    localparam int LAT = 2;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // Main instance, MEM_LAT = 2
    logic        if_req = 0, if_gnt, if_rvalid;
    logic [31:0] if_addr = 0, if_rdata;
    logic        d_req = 0, d_we = 0, d_gnt, d_rvalid;
    logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
    logic [3:0]  d_be = 0;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Second instance, MEM_LAT = 1
    logic        l1_if_req = 0, l1_if_gnt, l1_if_rvalid;
    logic [31:0] l1_if_addr = 0, l1_if_rdata;
    logic        l1_d_req = 0, l1_d_we = 0, l1_d_gnt, l1_d_rvalid;
    logic [31:0] l1_d_addr = 0, l1_d_wdata = 0, l1_d_rdata;
    logic [3:0]  l1_d_be = 0;
    logic        l1_mem_en, l1_mem_we, l1_busy;
    logic [31:0] l1_mem_addr, l1_mem_wdata;
    logic [31:0] l1_mem_rdata = 32'h1234_5678;
    logic [3:0]  l1_mem_be;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
        .clock(clock), .reset(reset),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_gnt(l1_if_gnt),
        .if_rvalid(l1_if_rvalid), .if_rdata(l1_if_rdata),
        .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
        .d_be(l1_d_be), .d_gnt(l1_d_gnt), .d_rvalid(l1_d_rvalid), .d_rdata(l1_d_rdata),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_be(l1_mem_be), .mem_rdata(l1_mem_rdata),
        .busy(l1_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: reads return the stored word, or ~addr if never written.
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] rd_q = 32'h0;
    logic [31:0] wr_tmp;
    assign mem_rdata = rd_q;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : ~a;
    endfunction

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) begin
                wr_tmp = mem_read(mem_addr);
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) wr_tmp[8*b +: 8] = mem_wdata[8*b +: 8];
                mem_model[mem_addr] = wr_tmp;
            end else begin
                rd_q <= mem_read(mem_addr);
            end
        end
    end

    // Scoreboard
    typedef struct {
        logic        id;      // 1 = data port
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          issue_cyc;
    } txn_t;

    txn_t exp_q[$];
    txn_t resp_q[$];
    txn_t mon_t;

    function automatic txn_t mk(input logic id, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic [31:0] rdata);
        txn_t t;
        t.id = id; t.we = we; t.addr = addr; t.wdata = wdata; t.be = be;
        t.rdata = rdata; t.issue_cyc = 0;
        return t;
    endfunction

    // Monitor: compare issue and response cycles against the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            if (mem_en) begin
                check("issue_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    mon_t = exp_q.pop_front();
                    check("gnt_onehot", {if_gnt, d_gnt}, mon_t.id ? 2'b01 : 2'b10);
                    check("mem_addr", mem_addr, mon_t.addr);
                    check("mem_we", mem_we, mon_t.id & mon_t.we);
                    check("mem_be", mem_be, mon_t.id ? mon_t.be : 4'h0);
                    if (mon_t.id && mon_t.we) check("mem_wdata", mem_wdata, mon_t.wdata);
                    mon_t.issue_cyc = cyc;
                    resp_q.push_back(mon_t);
                end
            end
            if (if_rvalid || d_rvalid) begin
                check("rvalid_pending", 64'(resp_q.size() > 0), 64'd1);
                if (resp_q.size() > 0) begin
                    mon_t = resp_q.pop_front();
                    check("rvalid_onehot", {if_rvalid, d_rvalid}, mon_t.id ? 2'b01 : 2'b10);
                    check("rvalid_latency", cyc - mon_t.issue_cyc, LAT);
                    check("rdata", mon_t.id ? d_rdata : if_rdata, mon_t.rdata);
                    check("loser_rdata", mon_t.id ? if_rdata : d_rdata, 0);
                end
            end
        end
    end

    typedef struct {
        logic        d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 30 && !idle; i++) begin
            @(negedge clock);
            idle = !busy;
        end
        if (!idle) check("idle_timeout", 1, 0);
    endtask

    // One isolated access from an idle arbiter.
    task automatic do_access(input vec_t v);
        int req_cyc, gnt_cyc, busy_n;
        bit got = 0;
        @(posedge clock); #1;
        exp_q.push_back(mk(v.d, v.we, v.addr, v.wdata, v.be, v.rdata));
        req_cyc = cyc;
        busy_n  = 0;
        gnt_cyc = 0;
        if (v.d) begin
            d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
        end else begin
            if_req = 1; if_addr = v.addr;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (busy) busy_n++;
            if (v.d ? d_gnt : if_gnt) begin
                got = 1;
                gnt_cyc = cyc;
            end
        end
        check("gnt_seen", got, 1);
        check("gnt_latency", gnt_cyc - req_cyc, 1);
        @(posedge clock); #1;
        d_req = 0; if_req = 0; d_we = 0; d_be = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!busy) break;
            busy_n++;
        end
        check("busy_cycles", busy_n, LAT + 1);
    endtask

    // Both ports request in the same cycle and hold until granted.
    task automatic contend(input bit data_first, input logic [31:0] faddr,
                           input logic [31:0] daddr, input logic [31:0] dwdata);
        int  d_cyc = 0, f_cyc = 0, gap = 0;
        bit  got_d = 0, got_f = 0, drop_d, drop_f;
        txn_t td, tf;
        td = mk(1'b1, 1'b1, daddr, dwdata, 4'hF, 32'h0);
        tf = mk(1'b0, 1'b0, faddr, 32'h0, 4'h0, ~faddr);
        @(posedge clock); #1;
        if (data_first) begin
            exp_q.push_back(td); exp_q.push_back(tf);
        end else begin
            exp_q.push_back(tf); exp_q.push_back(td);
        end
        d_req = 1; d_we = 1; d_addr = daddr; d_wdata = dwdata; d_be = 4'hF;
        if_req = 1; if_addr = faddr;
        for (int i = 0; i < 40 && !(got_d && got_f); i++) begin
            @(negedge clock);
            drop_d = 0; drop_f = 0;
            if ((got_d ^ got_f) && !busy) gap++;
            if (d_gnt)  begin got_d = 1; d_cyc = cyc; drop_d = 1; end
            if (if_gnt) begin got_f = 1; f_cyc = cyc; drop_f = 1; end
            @(posedge clock); #1;
            if (drop_d) begin d_req = 0; d_we = 0; d_be = 0; end
            if (drop_f) if_req = 0;
        end
        check("contend_both_granted", {got_d, got_f}, 2'b11);
        check("contend_spacing", data_first ? (f_cyc - d_cyc) : (d_cyc - f_cyc), LAT + 1);
        check("contend_no_idle_gap", gap, 0);
        wait_idle();
    endtask

    initial begin
        int gcyc [4];
        int n, gap, rv, rc, gc;
        bit got, drop;

        mem_model[32'h100] = 32'h0050_0093;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 32'h0050_0093};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         4'hF, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_2000, 32'h1122_3344, 4'h3, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         4'hF, 32'hDEAD_3344};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         4'h0, 32'hFFFF_FEFB};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_2004, 32'hAABB_CCDD, 4'h9, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0,         4'hF, 32'hAAFF_DFDD};

        // Reset state
        repeat (2) @(negedge clock);
        check("reset_outputs", |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                                 mem_en, mem_we, mem_addr, mem_wdata, mem_be}, 0);
        check("reset_busy", busy, 0);
        @(posedge clock); #2;
        reset = 1;

        // Table of isolated accesses
        for (int i = 0; i < NV; i++) do_access(vecs[i]);

        // Contention after a fetch grant: data wins in both modes
        do_access('{1'b0, 1'b0, 32'h0000_0400, 32'h0, 4'h0, 32'hFFFF_FBFF});
        contend(1'b1, 32'h0000_0500, 32'h0000_3000, 32'h0101_0101);
        // Contention after a data grant: round-robin hands it to fetch
        do_access('{1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 32'h0101_0101});
        contend(!RR, 32'h0000_0504, 32'h0000_3004, 32'h0202_0202);

        // Back-to-back fetches, if_req held for four accesses
        for (int k = 0; k < 4; k++)
            exp_q.push_back(mk(1'b0, 1'b0, 32'h600 + 32'(4 * k), 32'h0, 4'h0,
                               ~(32'h600 + 32'(4 * k))));
        @(posedge clock); #1;
        if_req = 1; if_addr = 32'h600;
        n = 0; gap = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clock);
            drop = 0;
            if (n > 0 && !busy) gap++;
            if (if_gnt) begin gcyc[n] = cyc; n++; drop = 1; end
            @(posedge clock); #1;
            if (drop) begin
                if (n < 4) if_addr = 32'h600 + 32'(4 * n);
                else       if_req = 0;
            end
        end
        check("b2b_count", n, 4);
        for (int k = 1; k < 4; k++) check("b2b_spacing", gcyc[k] - gcyc[k-1], LAT + 1);
        check("b2b_busy_gap", gap, 0);
        wait_idle();

        // MEM_LAT = 1 instance: single load
        @(posedge clock); #1;
        l1_d_req = 1; l1_d_addr = 32'h40; l1_d_be = 4'hF;
        rc = cyc; gc = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (l1_d_gnt) begin
                got = 1; gc = cyc;
                check("l1_mem_en", {l1_mem_en, l1_mem_we}, 2'b10);
                check("l1_mem_addr", l1_mem_addr, 32'h40);
            end
        end
        check("l1_gnt_latency", gc - rc, 1);
        @(posedge clock); #1;
        l1_d_req = 0;
        @(negedge clock);
        check("l1_rvalid", {l1_d_rvalid, l1_if_rvalid}, 2'b10);
        check("l1_rdata", l1_d_rdata, 32'h1234_5678);
        check("l1_rvalid_cycle", cyc - rc, 2);
        @(negedge clock);
        check("l1_idle_after", {l1_busy, l1_d_rvalid}, 2'b00);

        // Reset in WAIT of a load
        @(posedge clock); #1;
        exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 32'hDEAD_3344));
        d_req = 1; d_we = 0; d_addr = 32'h2000; d_be = 4'hF;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = d_gnt;
        end
        check("rst_gnt_seen", got, 1);
        @(posedge clock); #1;
        d_req = 0; d_be = 0;
        reset = 0;
        #1;
        check("rst_mid_outputs", |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                                   mem_en, mem_we, mem_addr, mem_wdata, mem_be}, 0);
        check("rst_mid_busy", busy, 0);
        resp_q.delete();
        @(negedge clock);
        @(posedge clock); #2;
        reset = 1;
        rv = 0;
        repeat (6) begin
            @(negedge clock);
            if (d_rvalid || if_rvalid) rv++;
        end
        check("rst_no_rvalid", rv, 0);
        do_access('{1'b0, 1'b0, 32'h0000_0700, 32'h0, 4'h0, 32'hFFFF_F8FF});

        check("exp_q_drained", exp_q.size(), 0);
        check("resp_q_drained", resp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
